// File: rtl/if_fetch_reader_if.sv
// rtl/if_fetch_reader_if.sv - memory read bus and IF/ID slot bundle for if_fetch_reader
//
// Purpose: groups the instruction-memory request/acknowledge bus and the
// decode-side slot handshake of the fetch reader.
// Signals:
//   mem_req_o    read request to instruction memory (fetch side drives)
//   mem_addr_o   read address (fetch side drives)
//   mem_ack_i    memory acknowledge; mem_rdata_i valid in the same cycle
//   mem_rdata_i  instruction word from memory
//   id_valid_o   slot holds an instruction for decode (fetch side drives)
//   id_ready_i   decode accepts the slot this cycle
//   id_instr_o   instruction word in the slot
//   id_pc_o      address of id_instr_o
//   id_exc_o     fetch address exception flag
// Modports: master = fetch reader, slave = memory + decode environment.
interface if_fetch_reader_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_exc_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_ack_i, mem_rdata_i,
    output id_valid_o, id_instr_o, id_pc_o, id_exc_o,
    input  id_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_ack_i, mem_rdata_i,
    input  id_valid_o, id_instr_o, id_pc_o, id_exc_o,
    output id_ready_i
  );
endinterface

// File: rtl/if_fetch_reader.sv
// rtl/if_fetch_reader.sv - instruction-fetch reader between PC and the IF/ID slot
//
// Purpose: issues one request/acknowledge read per fetch address against
// variable-latency instruction memory, holds the returned word in a
// single-entry slot for decode, and generates the PC write enable.
// Ports:
//   clk      clock, all state updates on posedge
//   rst      synchronous active-high reset
//   pc_i     current PC (fetch address)
//   pc_we_o  PC write enable (combinational): fetch issued or redirect
//   flush_i  redirect: kills the slot and any in-flight fetch
//   bus      if_fetch_reader_if.master: memory bus + decode slot
// Configuration macro: FETCH_ADDR_CHECK_EN
//   defined   - out-of-range or misaligned fetch addresses are not sent to
//               memory; a nop with id_exc_o=1 is placed in the slot instead
//   undefined - every address goes to memory, id_exc_o stays 0
module if_fetch_reader #(
  parameter logic [31:0] ADDR_LO = 32'h0000_3000,
  parameter logic [31:0] ADDR_HI = 32'h0000_6FFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_i,
  output logic                pc_we_o,
  input  logic                flush_i,
  if_fetch_reader_if.master   bus
);

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_exc_q, id_exc_d;

  logic slot_free;
  logic issue;
  logic addr_bad;

  assign slot_free = !id_valid_q || bus.id_ready_i;
  assign issue     = (state_q == IDLE) && slot_free && !flush_i && !rst;
  assign pc_we_o   = issue || (flush_i && !rst);

  // Folds to 0 when the check is compiled out.
  assign addr_bad = CHECK_EN &&
                    ((pc_i < ADDR_LO) || (pc_i > ADDR_HI) || (pc_i[1:0] != 2'b00));

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_exc_d   = id_exc_q;

    // Consumption first; a load in the same cycle overrides it below.
    if (id_valid_q && bus.id_ready_i) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (issue) begin
          if (addr_bad) begin
            // Bad address never reaches memory; decode sees a faulting nop.
            id_valid_d = 1'b1;
            id_instr_d = 32'h0;
            id_pc_d    = pc_i;
            id_exc_d   = 1'b1;
          end else begin
            mem_addr_d = pc_i;
            mem_req_d  = 1'b1;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!flush_i) begin
            id_valid_d = 1'b1;
            id_instr_d = bus.mem_rdata_i;
            id_pc_d    = mem_addr_q;
            id_exc_d   = 1'b0;
          end
        end else if (flush_i) begin
          // Request must stay up until memory answers; its data is dropped.
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (flush_i) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= 32'h0;
      id_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_exc_q   <= id_exc_d;
    end
  end

  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.id_valid_o = id_valid_q;
  assign bus.id_instr_o = id_instr_q;
  assign bus.id_pc_o    = id_pc_q;
  assign bus.id_exc_o   = id_exc_q;

endmodule

// File: doc/if_fetch_reader.md
# if_fetch_reader

Instruction-fetch reader for the pipelined MIPS core. It sits between the program counter and the IF/ID boundary. Each cycle it takes the current fetch address, runs a request/acknowledge read against variable-latency instruction memory, and holds the returned instruction in a single-entry slot for decode. It generates the program counter's write enable, so PC advances only when a fetch is accepted or a redirect occurs.

## Interface
Parameters:
- ADDR_LO, 32'h00003000, lowest legal instruction address
- ADDR_HI, 32'h00006FFF, highest legal instruction address (inclusive)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- pc_i  in  32  current PC value (fetch address)
- pc_we_o  out  1  PC write enable; combinational
- flush_i  in  1  redirect: kill the slot and any in-flight fetch
- mem_req_o  out  1  read request to instruction memory; registered
- mem_addr_o  out  32  read address; registered
- mem_ack_i  in  1  memory acknowledge; mem_rdata_i is valid in the same cycle
- mem_rdata_i  in  32  instruction word
- id_valid_o  out  1  slot holds an instruction for decode
- id_ready_i  in  1  decode accepts the slot this cycle
- id_instr_o  out  32  instruction word
- id_pc_o  out  32  address of id_instr_o
- id_exc_o  out  1  fetch address exception (see Configuration)

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; the result is kept.
  - DROP: request outstanding; the result is discarded.
- slot_free = !id_valid_o || id_ready_i.
- issue = (state==IDLE) && slot_free && !flush_i && !rst.
- pc_we_o = issue || (flush_i && !rst). On flush, PC loads the redirect NPC; no fetch is issued that cycle.
- IDLE, issue: mem_addr_o<=pc_i, mem_req_o<=1, go to WAIT.
- WAIT: mem_req_o stays 1 until mem_ack_i. mem_addr_o is stable.
  - On ack without flush: id_instr_o<=mem_rdata_i, id_pc_o<=mem_addr_o, id_valid_o<=1, id_exc_o<=0, mem_req_o<=0, go to IDLE.
  - flush_i without ack: go to DROP; mem_req_o stays 1.
  - flush_i with ack in the same cycle: discard data, mem_req_o<=0, go to IDLE.
- DROP: mem_req_o stays 1 until ack. Data is discarded. On ack: mem_req_o<=0, go to IDLE. flush_i in DROP has no further effect.
- Slot consumption: if id_valid_o && id_ready_i and no load this cycle, id_valid_o<=0.
- flush_i always clears id_valid_o, regardless of id_ready_i.
- Only one fetch is ever outstanding, so an ack can never meet a full slot.

## Timing
- Reset values: state IDLE, mem_req_o 0, mem_addr_o 0, id_valid_o 0, id_instr_o 0, id_pc_o 0, id_exc_o 0. pc_we_o is 0 while rst is high.
- rst mid-fetch abandons the request. Memory must tolerate mem_req_o dropping before ack.
- Latency: issue in cycle T; mem_req_o high from T+1. An ack in cycle T+k (k≥1) makes id_valid_o high at T+k+1.
- Peak throughput: one instruction per 2 cycles (ack in the first WAIT cycle).
- Issue takes priority over nothing else; flush_i beats issue.

## Configuration
- FETCH_ADDR_CHECK_EN defined:
  - An issue cycle where pc_i<ADDR_LO, pc_i>ADDR_HI, or pc_i[1:0]!=0 sends no memory request.
  - Next cycle: id_valid_o=1, id_instr_o=32'h0 (nop), id_pc_o=pc_i, id_exc_o=1. State returns to/stays in IDLE.
  - pc_we_o still pulses in the issue cycle.
- FETCH_ADDR_CHECK_EN undefined: no range or alignment check; all addresses go to memory; id_exc_o is constant 0.

## Test plan
- Reset, then pc_i=0x3000, id_ready_i=1, ack one cycle after mem_req_o rises, rdata=0x3C010001 -> pc_we_o pulses once; mem_addr_o=0x3000; id_valid_o=1, id_instr_o=0x3C010001, id_pc_o=0x3000.
- Ack delayed 5 cycles -> mem_req_o high and mem_addr_o stable for 5 cycles; pc_we_o=0 throughout; id_valid_o rises the cycle after ack.
- id_ready_i=0 with slot full -> no issue and pc_we_o=0 until id_ready_i=1. In that cycle issue occurs and the slot clears; the next instruction loads after its ack.
- flush_i in the second WAIT cycle, ack two cycles later with rdata=0xDEADBEEF -> pc_we_o=1 in the flush cycle; id_valid_o stays 0; the next fetch issues from the new pc_i after the ack.
- rst asserted during WAIT -> next cycle mem_req_o=0 and id_valid_o=0; a later stray ack is ignored.
- FETCH_ADDR_CHECK_EN defined, pc_i=0x7000, then 0x3002 -> mem_req_o never rises; each produces id_exc_o=1, id_instr_o=0, with id_pc_o=0x7000 and 0x3002 respectively. Undefined: requests are issued, id_exc_o=0.
